// File: rtl/ldm_wb_seq.sv
// Write-back sequencer for LDM-style multi-register loads: drains a register
// list in ascending order onto the single register-file write port.
module ldm_wb_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int REGFILE_WIDTH = 4,
    parameter int NUM_REGS      = 1 << REGFILE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [NUM_REGS-1:0]      cmd_reglist,
    input  logic [REGFILE_WIDTH-1:0] cmd_base,
    input  logic                     cmd_wb,
    input  logic [DATA_WIDTH-1:0]    cmd_wbval,
    input  logic                     dat_valid,
    output logic                     dat_ready,
    input  logic [DATA_WIDTH-1:0]    dat_in,
    output logic [REGFILE_WIDTH-1:0] WADD,
    output logic [DATA_WIDTH-1:0]    WDAT,
    output logic                     WEN,
    output logic                     busy,
    output logic                     done
);

    // state  | meaning
    // S_IDLE | waiting for a command
    // S_LOAD | writing one accepted data word per cycle to the lowest pending register
    // S_BASE | writing the updated base value
    // S_DONE | transfer finished; done is raised on the following cycle
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BASE, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [NUM_REGS-1:0]      pend_q, pend_d, pend_rest;
    logic [REGFILE_WIDTH-1:0] base_q, base_d, wadd_q, wadd_d, tgt;
    logic [DATA_WIDTH-1:0]    wbval_q, wbval_d, wdat_q, wdat_d;
    logic                     wb_q, wb_d, wen_q, wen_d, done_q, done_d;

    assign cmd_ready = (state_q == S_IDLE);
    assign dat_ready = (state_q == S_LOAD);
    assign busy      = (state_q != S_IDLE);
    assign WADD      = wadd_q;
    assign WDAT      = wdat_q;
    assign WEN       = wen_q;
    assign done      = done_q;

    // Lowest set bit wins, giving ascending register order.
    always_comb begin
        tgt = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (pend_q[i]) tgt = REGFILE_WIDTH'(i);
        end
    end

    assign pend_rest = pend_q & (pend_q - NUM_REGS'(1));

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        base_d  = base_q;
        wb_d    = wb_q;
        wbval_d = wbval_q;
        wen_d   = 1'b0;
        wadd_d  = wadd_q;
        wdat_d  = wdat_q;
        done_d  = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pend_d  = cmd_reglist;
                    base_d  = cmd_base;
                    // A loaded base register overrides the writeback value.
                    wb_d    = cmd_wb & ~cmd_reglist[cmd_base];
                    wbval_d = cmd_wbval;
                    if (|cmd_reglist)                      state_d = S_LOAD;
                    else if (cmd_wb & ~cmd_reglist[cmd_base]) state_d = S_BASE;
                    else                                   state_d = S_DONE;
                end
            end
            S_LOAD: begin
                if (dat_valid) begin
                    wen_d  = 1'b1;
                    wadd_d = tgt;
                    wdat_d = dat_in;
                    pend_d = pend_rest;
                    if (pend_rest == '0) state_d = wb_q ? S_BASE : S_DONE;
                end
            end
            S_BASE: begin
                wen_d   = 1'b1;
                wadd_d  = base_q;
                wdat_d  = wbval_q;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            base_q  <= '0;
            wb_q    <= 1'b0;
            wbval_q <= '0;
            wen_q   <= 1'b0;
            wadd_q  <= '0;
            wdat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            base_q  <= base_d;
            wb_q    <= wb_d;
            wbval_q <= wbval_d;
            wen_q   <= wen_d;
            wadd_q  <= wadd_d;
            wdat_q  <= wdat_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ldm_wb_seq.sv
// Bench for ldm_wb_seq: directed and randomized transfers checked against an
// event-timed model of the expected register-file write stream.
module tb_ldm_wb_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_wb, dat_valid;
    logic [15:0] cmd_reglist;
    logic [3:0]  cmd_base;
    logic [31:0] cmd_wbval, dat_in;
    logic        cmd_ready, dat_ready, WEN, busy, done;
    logic [3:0]  WADD;
    logic [31:0] WDAT;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rf_obs[16];
    logic [31:0] rf_exp[16];
    logic [31:0] fixed_words[16];

    ldm_wb_seq #(.DATA_WIDTH(32), .REGFILE_WIDTH(4), .NUM_REGS(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reglist(cmd_reglist),
        .cmd_base(cmd_base), .cmd_wb(cmd_wb), .cmd_wbval(cmd_wbval),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_in(dat_in),
        .WADD(WADD), .WDAT(WDAT), .WEN(WEN), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_r%0d", tag, i), rf_obs[i], rf_exp[i]);
    endtask

    // Cycle k = the k-th falling edge; outputs sampled there reflect rising edge k-1,
    // inputs driven there are seen by rising edge k.
    task automatic run_cmd(input string tag, input logic [15:0] rl, input logic [3:0] base,
                           input logic wb, input logic [31:0] wbval, input int stall_pct,
                           input logic use_fixed);
        int          addrs[16];
        logic [31:0] words[16];
        int          n = 0, k = 0, t0 = 0, wacc = 0, done_at = 1 << 30, last;
        logic        accepted = 1'b0, wb_eff, exp_wen, load_exp, busy_exp, dv;
        for (int i = 0; i < 16; i++) begin
            if (rl[i]) begin addrs[n] = i; n++; end
            words[i] = use_fixed ? fixed_words[i] : $urandom();
        end
        wb_eff = wb && !rl[base];
        wq.delete();
        forever begin
            @(negedge clk);
            exp_wen  = (wq.size() > 0) && (wq[0].cyc == k);
            load_exp = accepted && (k > t0) && (wacc < n);
            busy_exp = accepted && (k > t0) && (k < done_at);
            chk({tag, "_wen"}, WEN, exp_wen);
            if (exp_wen) begin
                chk({tag, "_wadd"}, WADD, wq[0].a);
                chk({tag, "_wdat"}, WDAT, wq[0].d);
                void'(wq.pop_front());
            end
            if (WEN === 1'b1) rf_obs[WADD] = WDAT;
            chk({tag, "_done"}, done, (k == done_at));
            chk({tag, "_dat_ready"}, dat_ready, load_exp);
            chk({tag, "_busy"}, busy, busy_exp);
            chk({tag, "_cmd_ready"}, cmd_ready, !busy_exp);
            if (k == done_at) begin
                cmd_valid = 1'b0;
                dat_valid = 1'b0;
                break;
            end
            if (k > 600) begin
                chk({tag, "_timeout"}, k, done_at);
                break;
            end
            if (!accepted) begin
                cmd_valid   = 1'b1;
                cmd_reglist = rl;
                cmd_base    = base;
                cmd_wb      = wb;
                cmd_wbval   = wbval;
                accepted    = 1'b1;
                t0          = k;
                if (n == 0) begin
                    last = k;
                    if (wb_eff) begin
                        wq.push_back('{last + 2, base, wbval});
                        rf_exp[base] = wbval;
                    end
                    done_at = last + (wb_eff ? 3 : 2);
                end
            end else begin
                // Junk commands while busy must be ignored.
                cmd_valid   = busy_exp ? 1'($urandom_range(1)) : 1'b0;
                cmd_reglist = 16'($urandom());
                cmd_base    = 4'($urandom());
                cmd_wb      = 1'($urandom());
                cmd_wbval   = $urandom();
            end
            if (load_exp) begin
                dv        = ($urandom_range(99) >= stall_pct);
                dat_valid = dv;
                dat_in    = dv ? words[wacc] : $urandom();
                if (dv) begin
                    wq.push_back('{k + 1, 4'(addrs[wacc]), words[wacc]});
                    rf_exp[addrs[wacc]] = words[wacc];
                    wacc++;
                    if (wacc == n) begin
                        last = k;
                        if (wb_eff) begin
                            wq.push_back('{last + 2, base, wbval});
                            rf_exp[base] = wbval;
                        end
                        done_at = last + (wb_eff ? 3 : 2);
                    end
                end
            end else begin
                dat_valid = 1'($urandom_range(1));
                dat_in    = $urandom();
            end
            k++;
        end
        chk({tag, "_pending_writes"}, wq.size(), 0);
        check_rf(tag);
    endtask

    initial begin
        logic [15:0] rl;
        logic [31:0] w0, w1;
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_reglist = '0; cmd_base = '0; cmd_wb = 1'b0; cmd_wbval = '0;
        dat_valid = 1'b0; dat_in = '0;
        for (int i = 0; i < 16; i++) begin rf_obs[i] = '0; rf_exp[i] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_wen", WEN, 1'b0);
        chk("rst_wadd", WADD, 4'h0);
        chk("rst_wdat", WDAT, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_dat_ready", dat_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        fixed_words[0] = 32'hAAAA0001; fixed_words[1] = 32'hAAAA0002; fixed_words[2] = 32'hAAAA0003;
        run_cmd("simple", 16'h0025, 4'd7, 1'b0, 32'h0, 0, 1'b1);
        run_cmd("basewb", 16'h000C, 4'd13, 1'b1, 32'h00001008, 0, 1'b0);
        fixed_words[0] = 32'h11111111; fixed_words[1] = 32'h22222222;
        run_cmd("base_in_list", 16'h2001, 4'd13, 1'b1, 32'hDEADBEEF, 0, 1'b1);
        run_cmd("stall_all", 16'hFFFF, 4'd0, 1'b1, 32'h12345678, 50, 1'b0);
        run_cmd("empty_wb", 16'h0000, 4'd1, 1'b1, 32'h00000040, 0, 1'b0);
        run_cmd("empty_nowb", 16'h0000, 4'd1, 1'b0, 32'h00000080, 0, 1'b0);
        run_cmd("only_r15_wb", 16'h8000, 4'd15, 1'b1, 32'hCAFEF00D, 30, 1'b0);

        for (int t = 0; t < 20; t++) begin
            rl = 16'($urandom());
            if (t % 3 == 0) rl = rl & 16'($urandom()) & 16'($urandom());
            run_cmd($sformatf("rand%0d", t), rl, 4'($urandom()), 1'($urandom()),
                    $urandom(), $urandom_range(70), 1'b0);
        end

        // Abort mid-load: two words written, then asynchronous reset.
        w0 = $urandom(); w1 = $urandom();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_reglist = 16'h00F0; cmd_base = 4'd2; cmd_wb = 1'b1;
        cmd_wbval = 32'h0BAD0BAD;
        @(negedge clk);
        chk("abort_dat_ready", dat_ready, 1'b1);
        cmd_valid = 1'b0; dat_valid = 1'b1; dat_in = w0;
        @(negedge clk);
        chk("abort_wen0", WEN, 1'b1);
        chk("abort_wadd0", WADD, 4'd4);
        chk("abort_wdat0", WDAT, w0);
        dat_in = w1;
        @(negedge clk);
        chk("abort_wen1", WEN, 1'b1);
        chk("abort_wadd1", WADD, 4'd5);
        chk("abort_wdat1", WDAT, w1);
        dat_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("abort_wen_async", WEN, 1'b0);
        chk("abort_busy_async", busy, 1'b0);
        chk("abort_cmd_ready_async", cmd_ready, 1'b1);
        chk("abort_dat_ready_async", dat_ready, 1'b0);
        chk("abort_wadd_async", WADD, 4'h0);
        chk("abort_wdat_async", WDAT, 32'h0);
        chk("abort_done_async", done, 1'b0);
        dat_valid = 1'b1; dat_in = $urandom();
        repeat (2) begin
            @(negedge clk);
            chk("abort_wen_in_rst", WEN, 1'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_cmd_ready_after", cmd_ready, 1'b1);
            chk("abort_busy_after", busy, 1'b0);
            chk("abort_wen_after", WEN, 1'b0);
            chk("abort_done_after", done, 1'b0);
        end
        dat_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin rf_obs[i] = '0; rf_exp[i] = '0; end
        run_cmd("post_abort", 16'h00F0, 4'd2, 1'b1, 32'h00002000, 20, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/ldm_wb_seq.md
Name: ldm_wb_seq

Overview:
- Write-back sequencer that drives the register file's single write port (WADD/WDAT/WEN) for ARM LDM-style multi-register loads.
- Accepts one command per transfer: a 16-bit register list, a base register, an optional base-writeback value.
- Accepts load data words through a valid/ready stream and writes them to registers in ascending register order, one per cycle.
- Optionally finishes with a base writeback, then pulses done. Sits between the load/store unit and the register file.

Parameters:
DATA_WIDTH, 32, register data width
REGFILE_WIDTH, 4, register address width
NUM_REGS, 16, register-list width (= 1 << REGFILE_WIDTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_reglist  input  NUM_REGS  bit i set = load register i
cmd_base  input  REGFILE_WIDTH  base register number
cmd_wb  input  1  perform base writeback after loads
cmd_wbval  input  DATA_WIDTH  updated base value
dat_valid  input  1  load data word present
dat_ready  output  1  sequencer accepts data word this cycle
dat_in  input  DATA_WIDTH  load data word
WADD  output  REGFILE_WIDTH  register-file write address
WDAT  output  DATA_WIDTH  register-file write data
WEN  output  1  register-file write enable
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; WEN=0, WADD=0, WDAT=0, done=0, busy=0, pending mask=0. With state IDLE, cmd_ready=1 and dat_ready=0.
- Reset asserted mid-operation aborts the transfer immediately. Remaining writes and the base writeback are dropped, and WEN drops to 0 without waiting for a clock edge.
- cmd_ready = (state==IDLE); dat_ready = (state==LOAD). Both are combinational from state.
- WADD/WDAT/WEN/done are registered. A write reaches the register file the cycle after its handshake; there are no combinational paths from inputs to them.
- States: IDLE, LOAD, BASE, DONE.
- IDLE:
  - On cmd_valid, latch reglist into the pending mask, and latch base, wb and wbval.
  - Base writeback is suppressed if reglist[base]=1, because the loaded value wins: wb_eff = wb & ~reglist[base].
  - Next state: pending nonzero -> LOAD; else wb_eff -> BASE; else -> DONE.
- LOAD:
  - Target = lowest set bit of the pending mask.
  - On dat_valid&dat_ready, on the next edge: WEN=1, WADD=target, WDAT=dat_in, and that bit is cleared.
  - Without dat_valid: WEN=0 and the state holds, with no timeout.
  - When the cleared bit was the last one: next state BASE if wb_eff, else DONE.
  - Back-to-back data gives one write per cycle.
- BASE: on the next edge, WEN=1, WADD=base, WDAT=wbval; go to DONE.
- DONE: done=1 for exactly this cycle; WEN=0; next state IDLE. A new command is accepted no earlier than the following cycle.
- WEN is 0 in every cycle that is not a write cycle defined above. WADD/WDAT hold their last values when WEN=0.
- Commands arriving while busy are not accepted (cmd_ready=0); the sender holds cmd_valid.
- All 16 bits set gives 16 writes, r0..r15, in order.
- Writes to r15 are issued like any other register; branch handling is outside this block.

Test Plan:
- Reset: drive rst=0 mid-LOAD with reglist=16'h00F0 after 2 data words accepted -> WEN=0 immediately, no further writes; after rst=1, cmd_ready=1, busy=0.
- Simple list: reglist=16'h0025, wb=0, data AAAA0001, AAAA0002, AAAA0003 back-to-back -> WEN on 3 consecutive cycles, writing r0=AAAA0001, r2=AAAA0002, r5=AAAA0003; then done pulse 1 cycle; register-file readback matches.
- Base writeback: reglist=16'h000C, base=13, wb=1, wbval=00001008 -> r2 and r3 written, then r13=00001008 on the next cycle, then done.
- Base in list: reglist=16'h2001, base=13, wb=1, wbval=DEADBEEF, data 11111111, 22222222 -> r0=11111111, r13=22222222, no write of DEADBEEF; done follows the r13 write.
- Stalled data: reglist=16'hFFFF, dat_valid toggled on/off randomly -> exactly 16 writes to r0..r15 in order, WEN only after accepted words, dat_ready=1 throughout LOAD.
- Empty list: reglist=0, wb=1, base=1, wbval=00000040 -> single write r1=00000040, then done; with wb=0 -> no write, done 2 cycles after command acceptance.
